pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. Drives the enable and bubble-insert controls of the PC register and the FD, DX, XM and MW latches from three event sources: multiply/divide sequencing, load-use hazards and taken control transfers. Starts the multdiv unit and waits for it, with a watchdog timer. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_MAX_CYCLES, 40, watchdog limit in cycles for a single multdiv operation
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
fd_ins  input  32  instruction in FD latch (decode stage)
dx_ins  input  32  instruction in DX latch (execute stage)
ctrl_taken  input  1  execute stage resolved a taken branch, jump, jr or bex this cycle
md_ready  input  1  multdiv result valid, one-cycle pulse
pc_en  output  1  PC register write enable
fd_en  output  1  FD latch enable
dx_en  output  1  DX latch enable
xm_en  output  1  XM latch enable
mw_en  output  1  MW latch enable
fd_nop  output  1  load nop (32'b0) into FD on next edge
dx_nop  output  1  load nop into DX on next edge
xm_nop  output  1  load nop into XM on next edge
md_start  output  1  start pulse to multdiv, one cycle
md_timeout  output  1  sticky, watchdog expired, cleared only by reset
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]. R-type opcode 00000. lw 01000. mul = R-type with aluop 00110. div = R-type with aluop 00111.
- Reset (async, reset_n=0): state IDLE, watchdog 0, stall_cycles 0, md_timeout 0. All enables are driven to 1 and all nop/md_start outputs to 0 while reset is asserted.
- FSM states IDLE, MD_BUSY, MD_DONE. Outputs are Mealy on the current state and current inputs.
- IDLE, dx_ins is mul/div: md_start=1, next state MD_BUSY, watchdog loaded to 0. In this cycle pc_en=fd_en=dx_en=0 and xm_nop=1, which places a bubble ahead of the op.
- MD_BUSY: pc_en=fd_en=dx_en=0, xm_nop=1, md_start=0, watchdog increments.
  - md_ready=1 goes to MD_DONE.
  - If the watchdog reaches MD_MAX_CYCLES-1 without md_ready: set md_timeout and go to MD_DONE.
- MD_DONE (one cycle): all enables 1, no nops. The op advances into XM with its result. Next state is IDLE. The mul/div check is suppressed in this cycle so the same op does not restart.
- md_ready in IDLE is ignored.
- Load-use (IDLE only, no mul/div in DX): dx is lw, dx.rd != 0, and fd_ins reads that register. The read set is:
  - rs for every opcode except j, jal, setx;
  - rt for R-type;
  - rd for sw(00111), bne(00010), blt(00110), jr(00100).
  - Response: pc_en=fd_en=0 and dx_nop=1 for one cycle. XM and MW advance.
- Taken control (IDLE only): ctrl_taken=1 gives fd_nop=1 and dx_nop=1. All enables stay 1.
- Priority: reset > multdiv sequencing > ctrl_taken > load-use. When a load-use and ctrl_taken coincide, the flush wins and no stall occurs.
- ctrl_taken during MD_BUSY cannot occur, because DX is frozen on the mul/div. If it is asserted anyway, it is ignored.
- mw_en is always 1. A bubble from xm_nop drains through MW.
- stall_cycles increments on every clock edge where pc_en=0 and saturates at all-ones.
- Reset asserted mid-MD_BUSY returns the FSM to IDLE immediately. A late md_ready after reset is ignored.

Decomposition:
- Shared package/header holds the opcode constants (RTYPE, LW, SW, BNE, BLT, J, JAL, JR, SETX, BEX), the ALU opcodes MUL and DIV, the field bit ranges, and the FSM state encodings.
- One sub-module, hazard_decode: purely combinational. Computes dx_is_md, dx_is_lw, and fd_reads_rd_of_dx from fd_ins and dx_ins.
- The FSM, watchdog and counter stay in the top module.

Test Plan:
- Reset: reset_n=0 mid-run -> all enables 1, nops 0, stall_cycles 0, md_timeout 0 asynchronously, before the next clock edge.
- Load-use: dx=lw r5 and fd=add r1,r5,r2 -> exactly one cycle with pc_en=fd_en=0, dx_nop=1, stall_cycles=1. Same case with dx.rd=r0 -> no stall.
- Multdiv: dx=mul, md_ready pulses 33 cycles after md_start -> md_start high one cycle, pc_en=0 for 34 cycles (start cycle plus 33 busy cycles), MD_DONE cycle has all enables 1, then IDLE with no restart.
- Watchdog: dx=div, md_ready never asserted -> md_timeout=1 after MD_MAX_CYCLES=40 busy cycles, pipeline released, md_timeout stays 1 until reset.
- Branch: ctrl_taken=1 together with a load-use condition -> fd_nop=dx_nop=1, pc_en=1, no stall counted.
- Saturation: preload stall_cycles near all-ones (CNT_W=4 build) and hold a stall -> counter stops at 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, ALU codes,
// instruction field positions and sequencer states.
package pipe_hazard_ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  // Opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // ALU opcodes handled by the multdiv unit
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Multdiv sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } mdState_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side control bundle of the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      fd_ins;
  logic [31:0]      dx_ins;
  logic             ctrl_taken;
  logic             md_ready;
  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             xm_en;
  logic             mw_en;
  logic             fd_nop;
  logic             dx_nop;
  logic             xm_nop;
  logic             md_start;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline datapath / multdiv side
  modport master (
    output fd_ins, dx_ins, ctrl_taken, md_ready,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_nop, dx_nop, xm_nop,
           md_start, md_timeout, stall_cycles
  );

  // Hazard controller side
  modport slave (
    input  fd_ins, dx_ins, ctrl_taken, md_ready,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_nop, dx_nop, xm_nop,
           md_start, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_decode.sv
// Combinational instruction decode for hazard detection between FD and DX.
module hazard_decode
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] fd_ins,
  input  logic [31:0] dx_ins,
  output logic        dx_is_md,
  output logic        dx_is_lw,
  output logic        fd_reads_rd_of_dx
);

  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAlu;
  logic       readsRs, readsRt, readsRd;
  logic       unusedBits;

  assign fdOp  = fd_ins[OPC_HI:OPC_LO];
  assign fdRd  = fd_ins[RD_HI:RD_LO];
  assign fdRs  = fd_ins[RS_HI:RS_LO];
  assign fdRt  = fd_ins[RT_HI:RT_LO];
  assign dxOp  = dx_ins[OPC_HI:OPC_LO];
  assign dxRd  = dx_ins[RD_HI:RD_LO];
  assign dxAlu = dx_ins[ALU_HI:ALU_LO];

  assign unusedBits = ^{fd_ins[RT_LO-1:0], dx_ins[RS_HI:ALU_HI+1], dx_ins[ALU_LO-1:0]};

  // Classify DX and match FD's source registers against DX's destination
  always_comb begin
    dx_is_md = (dxOp == OP_RTYPE) && ((dxAlu == ALU_MUL) || (dxAlu == ALU_DIV));
    dx_is_lw = (dxOp == OP_LW);
    readsRs  = !((fdOp == OP_J) || (fdOp == OP_JAL) || (fdOp == OP_SETX)) && (fdRs == dxRd);
    readsRt  = (fdOp == OP_RTYPE) && (fdRt == dxRd);
    readsRd  = ((fdOp == OP_SW) || (fdOp == OP_BNE) || (fdOp == OP_BLT) || (fdOp == OP_JR))
               && (fdRd == dxRd);
    fd_reads_rd_of_dx = (dxRd != 5'd0) && (readsRs || readsRt || readsRd);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: multdiv start/wait with
// watchdog, load-use stall, taken-control flush, saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES - 1);

  mdState_e         state;
  logic [WD_W-1:0]  watchdog;
  logic             timeoutFlag;
  logic [CNT_W-1:0] stallCnt;
  logic             dxIsMd, dxIsLw, fdReadsDxRd;
  logic             pcEn, fdEn, dxEn, fdNop, dxNop, xmNop, mdStart;

  hazard_decode uDecode (
    .fd_ins            (hz.fd_ins),
    .dx_ins            (hz.dx_ins),
    .dx_is_md          (dxIsMd),
    .dx_is_lw          (dxIsLw),
    .fd_reads_rd_of_dx (fdReadsDxRd)
  );

  // Multdiv sequencer with watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      watchdog    <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dxIsMd) begin
            state    <= MD_BUSY;
            watchdog <= '0;
          end
        end
        MD_BUSY: begin
          if (hz.md_ready) begin
            state <= MD_DONE;
          end else if (watchdog == WD_LIMIT) begin
            timeoutFlag <= 1'b1;
            state       <= MD_DONE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        MD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Mealy control outputs; reset forces the free-running pattern asynchronously
  always_comb begin
    pcEn    = 1'b1;
    fdEn    = 1'b1;
    dxEn    = 1'b1;
    fdNop   = 1'b0;
    dxNop   = 1'b0;
    xmNop   = 1'b0;
    mdStart = 1'b0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (dxIsMd) begin
            pcEn    = 1'b0;
            fdEn    = 1'b0;
            dxEn    = 1'b0;
            xmNop   = 1'b1;
            mdStart = 1'b1;
          end else if (hz.ctrl_taken) begin
            fdNop = 1'b1;
            dxNop = 1'b1;
          end else if (dxIsLw && fdReadsDxRd) begin
            pcEn  = 1'b0;
            fdEn  = 1'b0;
            dxNop = 1'b1;
          end
        end
        MD_BUSY: begin
          pcEn  = 1'b0;
          fdEn  = 1'b0;
          dxEn  = 1'b0;
          xmNop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of edges taken with the PC held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCnt <= '0;
    end else if (!pcEn && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign hz.pc_en        = pcEn;
  assign hz.fd_en        = fdEn;
  assign hz.dx_en        = dxEn;
  assign hz.xm_en        = 1'b1;
  assign hz.mw_en        = 1'b1;
  assign hz.fd_nop       = fdNop;
  assign hz.dx_nop       = dxNop;
  assign hz.xm_nop       = xmNop;
  assign hz.md_start     = mdStart;
  assign hz.md_timeout   = timeoutFlag;
  assign hz.stall_cycles = stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized check of pipe_hazard_ctrl against a cycle-level
// behavioural model built from the instruction rules.
module tb_pipe_hazard_ctrl;

  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  busSmall ();

  pipe_hazard_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .hz(bus)
  );
  pipe_hazard_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(4)) dutSmall (
    .clk(clk), .reset_n(reset_n), .hz(busSmall)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          mdInFlight;    // multdiv op occupying the pipeline
  bit          releaseCycle;  // next cycle is the one-cycle release
  int          busyElapsed;   // busy cycles already completed
  bit          mTimeout;
  longint      mStall;
  int          mStallSmall;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int alu);
    logic [31:0] w;
    w = 32'(op) * 32'h0800_0000 + 32'(rd) * 32'h0040_0000 + 32'(rs) * 32'h0002_0000
      + 32'(rt) * 32'h0000_1000 + 32'(alu) * 32'd4;
    return w;
  endfunction

  function automatic int fld(input logic [31:0] w, input int lsb);
    return int'((w >> lsb) & 32'd31);
  endfunction

  function automatic bit isMulDiv(input logic [31:0] w);
    return fld(w, 27) == 0 && (fld(w, 2) == 6 || fld(w, 2) == 7);
  endfunction

  function automatic bit loadUse(input logic [31:0] dx, input logic [31:0] fd);
    int op, r;
    bit hit;
    op = fld(fd, 27);
    r  = fld(dx, 22);
    if (fld(dx, 27) != 8 || r == 0) return 0;
    hit = 0;
    if (!(op == 1 || op == 3 || op == 21) && fld(fd, 17) == r) hit = 1;
    if (op == 0 && fld(fd, 12) == r) hit = 1;
    if ((op == 7 || op == 2 || op == 6 || op == 4) && fld(fd, 22) == r) hit = 1;
    return hit;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctlOf(input logic pc, fd, dx, xm, mw, fn, dn, xn, st);
    return {pc, fd, dx, xm, mw, fn, dn, xn, st};
  endfunction

  task automatic drive(input logic [31:0] dx, input logic [31:0] fd, input bit taken,
                       input bit ready);
    bus.dx_ins = dx;      busSmall.dx_ins = dx;
    bus.fd_ins = fd;      busSmall.fd_ins = fd;
    bus.ctrl_taken = taken; busSmall.ctrl_taken = taken;
    bus.md_ready = ready;   busSmall.md_ready = ready;
  endtask

  task automatic modelReset();
    mdInFlight = 0; releaseCycle = 0; busyElapsed = 0;
    mTimeout = 0; mStall = 0; mStallSmall = 0;
  endtask

  // One pipeline cycle: apply inputs, compare mid-cycle, advance model at the edge
  task automatic step(input string tag, input logic [31:0] dx, input logic [31:0] fd,
                      input bit taken, input bit ready);
    logic [8:0] e;
    bit stallNow;
    drive(dx, fd, taken, ready);
    #3;
    if (releaseCycle)             e = 9'b11111_000_0;
    else if (mdInFlight)          e = 9'b00011_001_0;
    else if (isMulDiv(dx))        e = 9'b00011_001_1;
    else if (taken)               e = 9'b11111_110_0;
    else if (loadUse(dx, fd))     e = 9'b00111_010_0;
    else                          e = 9'b11111_000_0;
    check({tag, ".ctl"}, 64'(ctlOf(bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                                   bus.fd_nop, bus.dx_nop, bus.xm_nop, bus.md_start)), 64'(e));
    check({tag, ".ctl4"}, 64'(ctlOf(busSmall.pc_en, busSmall.fd_en, busSmall.dx_en,
                                    busSmall.xm_en, busSmall.mw_en, busSmall.fd_nop,
                                    busSmall.dx_nop, busSmall.xm_nop, busSmall.md_start)),
          64'(e));
    check({tag, ".stall"}, 64'(bus.stall_cycles), 64'(mStall));
    check({tag, ".stall4"}, 64'(busSmall.stall_cycles), 64'(mStallSmall));
    check({tag, ".timeout"}, 64'(bus.md_timeout), 64'(mTimeout));
    stallNow = (e[8] == 1'b0);
    @(posedge clk);
    if (stallNow) begin
      if (mStall < 64'hFFFF_FFFF) mStall++;
      if (mStallSmall < 15) mStallSmall++;
    end
    if (releaseCycle) begin
      releaseCycle = 0;
    end else if (mdInFlight) begin
      busyElapsed++;
      if (ready || busyElapsed == MAXC) begin
        if (!ready) mTimeout = 1;
        mdInFlight = 0;
        releaseCycle = 1;
      end
    end else if (isMulDiv(dx)) begin
      mdInFlight = 1;
      busyElapsed = 0;
    end
    #1;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".ctl"}, 64'(ctlOf(bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                                   bus.fd_nop, bus.dx_nop, bus.xm_nop, bus.md_start)),
          64'h1F0);
    check({tag, ".stall"}, 64'(bus.stall_cycles), 64'd0);
    check({tag, ".timeout"}, 64'(bus.md_timeout), 64'd0);
  endtask

  function automatic logic [31:0] randIns();
    int r1, r2, r3;
    r1 = int'($urandom_range(0, 3));
    r2 = int'($urandom_range(0, 3));
    r3 = int'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: return mk(0, r1, r2, r3, 0);
      1: return mk(0, r1, r2, r3, 6);
      2: return mk(0, r1, r2, r3, 7);
      3, 4: return mk(8, r1, r2, 0, 0);
      5: return mk(7, r1, r2, 0, 0);
      6: return mk(2, r1, r2, 0, 0);
      7: return mk(1, r1, r2, r3, 0);
      8: return mk(4, r1, r2, r3, 0);
      default: return mk(21, r1, r2, r3, 0);
    endcase
  endfunction

  logic [31:0] nopI, lwR5, addUsesR5, lwR0, mulI, divI, swR5;
  logic [31:0] rdx, rfd;

  initial begin
    nopI      = 32'h0;
    lwR5      = mk(8, 5, 2, 0, 0);
    addUsesR5 = mk(0, 1, 5, 2, 0);
    lwR0      = mk(8, 0, 2, 0, 0);
    mulI      = mk(0, 3, 1, 2, 6);
    divI      = mk(0, 4, 1, 2, 7);
    swR5      = mk(7, 5, 9, 0, 0);
    modelReset();
    drive(nopI, nopI, 0, 0);
    #1;
    checkResetState("reset0");
    @(posedge clk);
    #1 reset_n = 1'b1;

    step("idle", nopI, nopI, 0, 0);
    step("lu", lwR5, addUsesR5, 0, 0);
    step("luAfter", nopI, addUsesR5, 0, 0);
    step("luR0", lwR0, mk(0, 1, 0, 0, 0), 0, 0);
    step("luSwRd", lwR5, swR5, 0, 0);
    step("luJ", lwR5, mk(1, 0, 5, 5, 0), 0, 0);
    step("brLu", lwR5, addUsesR5, 1, 0);
    step("readyIdle", nopI, nopI, 0, 1);

    step("mulStart", mulI, nopI, 0, 0);
    for (int i = 0; i < 32; i++) step("mulBusy", mulI, nopI, (i == 5), 0);
    step("mulReady", mulI, nopI, 0, 1);
    step("mulDone", mulI, nopI, 0, 0);
    step("mulIdle", nopI, nopI, 0, 0);

    step("divStart", divI, nopI, 0, 0);
    for (int i = 0; i < MAXC; i++) step("divBusy", divI, nopI, 0, 0);
    step("divDone", divI, nopI, 0, 0);
    step("divIdle", nopI, nopI, 0, 1);
    step("divSticky", nopI, nopI, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rdx = randIns();
      rfd = randIns();
      step("rand", rdx, rfd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
    end

    step("midStart", mulI, nopI, 0, 0);
    step("midBusy", mulI, nopI, 0, 0);
    step("midBusy", mulI, nopI, 0, 0);
    reset_n = 1'b0;
    #1;
    checkResetState("asyncReset");
    modelReset();
    drive(nopI, nopI, 0, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("lateReady", nopI, nopI, 0, 1);
    step("postReset", nopI, nopI, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
